// File: rtl/serializer_pkg.sv
// Shared types and helpers for the double-buffered frame serializer.
package serializer_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } bank_state_t;

   // A zero or oversized length means "send the whole frame".
   function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] n_samples);
      logic [31:0] eff;
      if ((len == 32'd0) || (len > n_samples)) begin
         eff = n_samples;
      end else begin
         eff = len;
      end
      return eff;
   endfunction

endpackage

// File: rtl/frame_serializer_bank.sv
// One frame buffer: sample storage, frame length and EMPTY/FULL state with a read port.
module frame_serializer_bank
   import serializer_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int N_SAMPLES = 8,
   parameter int LEN_W     = $clog2(N_SAMPLES) + 1,
   parameter int IDX_W     = $clog2(N_SAMPLES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 free,
   input  logic [BIT_WIDTH-1:0] load_msg [N_SAMPLES],
   input  logic [LEN_W-1:0]     load_len,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [BIT_WIDTH-1:0] rd_msg,
   output logic [LEN_W-1:0]     len,
   output bank_state_t          state
);

   logic [BIT_WIDTH-1:0] data_r [N_SAMPLES];
   logic [LEN_W-1:0]     len_r;
   bank_state_t          state_r;

   // Bank storage: load and free never coincide since load needs EMPTY and free needs FULL.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_SAMPLES; i++) begin
            data_r[i] <= '0;
         end
         len_r   <= '0;
         state_r <= EMPTY;
      end else if (load) begin
         data_r  <= load_msg;
         len_r   <= load_len;
         state_r <= FULL;
      end else if (free) begin
         state_r <= EMPTY;
      end
   end

   // Read port and status.
   always_comb begin
      rd_msg = data_r[rd_idx];
      len    = len_r;
      state  = state_r;
   end

endmodule

// File: rtl/frame_serializer.sv
// Double-buffered variable-length parallel-to-serial converter with last-word marker.
module frame_serializer
   import serializer_pkg::*;
#(
   parameter  int BIT_WIDTH = 32,
   parameter  int N_SAMPLES = 8,
   localparam int LEN_W     = $clog2(N_SAMPLES) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
   input  logic [LEN_W-1:0]     recv_len,
   input  logic                 recv_val,
   output logic                 recv_rdy,
   output logic [BIT_WIDTH-1:0] send_msg,
   output logic                 send_last,
   output logic                 send_val,
   input  logic                 send_rdy
);

   localparam int IDX_W = $clog2(N_SAMPLES);

   bank_state_t          state_s [2];
   logic [LEN_W-1:0]     len_s   [2];
   logic [BIT_WIDTH-1:0] msg_s   [2];
   logic [1:0]           load_s;
   logic [1:0]           free_s;
   logic [LEN_W-1:0]     eff_len_s;
   logic [LEN_W-1:0]     cur_len_s;
   logic                 recv_fire_s;
   logic                 send_fire_s;
   logic                 last_s;

   logic                 wr_bank_r;
   logic                 rd_bank_r;
   logic [IDX_W-1:0]     idx_r;

   assign eff_len_s = LEN_W'(clamp_len(32'(recv_len), 32'(N_SAMPLES)));

   for (genvar b = 0; b < 2; b++) begin : g_bank
      frame_serializer_bank #(
         .BIT_WIDTH (BIT_WIDTH),
         .N_SAMPLES (N_SAMPLES),
         .LEN_W     (LEN_W),
         .IDX_W     (IDX_W)
      ) u_bank (
         .clk      (clk),
         .reset    (reset),
         .load     (load_s[b]),
         .free     (free_s[b]),
         .load_msg (recv_msg),
         .load_len (eff_len_s),
         .rd_idx   (idx_r),
         .rd_msg   (msg_s[b]),
         .len      (len_s[b]),
         .state    (state_s[b])
      );
   end

   // Handshake, output mux and bank strobes; recv_rdy depends on registered state only.
   always_comb begin
      recv_rdy    = (state_s[wr_bank_r] == EMPTY);
      send_val    = (state_s[rd_bank_r] == FULL);
      send_msg    = msg_s[rd_bank_r];
      cur_len_s   = len_s[rd_bank_r];
      last_s      = send_val && ({1'b0, idx_r} == (cur_len_s - LEN_W'(1)));
      send_last   = last_s;
      recv_fire_s = recv_val && recv_rdy;
      send_fire_s = send_val && send_rdy;
      load_s      = 2'b00;
      free_s      = 2'b00;
      if (recv_fire_s) begin
         load_s[wr_bank_r] = 1'b1;
      end else begin
         load_s = 2'b00;
      end
      if (send_fire_s && last_s) begin
         free_s[rd_bank_r] = 1'b1;
      end else begin
         free_s = 2'b00;
      end
   end

   // Bank pointers and read index; everything holds while the output is stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_bank_r <= 1'b0;
         rd_bank_r <= 1'b0;
         idx_r     <= '0;
      end else begin
         if (recv_fire_s) begin
            wr_bank_r <= ~wr_bank_r;
         end
         if (send_fire_s) begin
            if (last_s) begin
               idx_r     <= '0;
               rd_bank_r <= ~rd_bank_r;
            end else begin
               idx_r <= idx_r + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: expected beats queued at receive fire, checked per output fire.
module tb_frame_serializer;

   localparam int BW = 32;
   localparam int NS = 8;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [BW-1:0] recv_msg [NS];
   logic [LW-1:0] recv_len = '0;
   logic          recv_val = 1'b0;
   logic          recv_rdy;
   logic [BW-1:0] send_msg;
   logic          send_last;
   logic          send_val;
   logic          send_rdy = 1'b0;

   int            total = 0;
   int            bad = 0;
   logic [BW:0]   sb [$];
   int            cyc = 0;
   int            fire_count = 0;
   int            last_fire_cyc = -10;
   int            run_len = 0;
   logic          stall_prev = 1'b0;
   logic [BW:0]   held = '0;
   int            rdy_mode = 0;
   int            rdy_ph = 0;

   frame_serializer #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) dut (
      .clk       (clk),
      .reset     (reset),
      .recv_msg  (recv_msg),
      .recv_len  (recv_len),
      .recv_val  (recv_val),
      .recv_rdy  (recv_rdy),
      .send_msg  (send_msg),
      .send_last (send_last),
      .send_val  (send_val),
      .send_rdy  (send_rdy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Downstream ready pattern: 0 always ready, 1 cycles 1,0,0, 2 always stalled.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: send_rdy = 1'b1;
         1: begin
            send_rdy = (rdy_ph == 0);
            rdy_ph   = (rdy_ph + 1) % 3;
         end
         default: send_rdy = 1'b0;
      endcase
   end

   // Output monitor: stall stability and scoreboard comparison on every accepted beat.
   always @(negedge clk) begin
      if (!reset) begin
         if (stall_prev) begin
            check("stall_val", 64'(send_val), 64'(1));
            check("stall_hold", 64'({send_last, send_msg}), 64'(held));
         end
         if (send_val && send_rdy) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               check("beat", 64'({send_last, send_msg}), 64'(sb.pop_front()));
            end
            fire_count++;
            run_len = (cyc == last_fire_cyc + 1) ? run_len + 1 : 1;
            last_fire_cyc = cyc;
         end
         stall_prev = send_val && !send_rdy;
         held = {send_last, send_msg};
      end else begin
         stall_prev = 1'b0;
      end
   end

   function automatic int eff_len(input logic [LW-1:0] len);
      return ((len == 4'd0) || (len > 4'd8)) ? NS : int'(len);
   endfunction

   task automatic load_frame(input logic [31:0] base, input logic [LW-1:0] len);
      int l = eff_len(len);
      for (int i = 0; i < NS; i++) begin
         recv_msg[i] = (i < l) ? base + 32'(i) : 32'hDEAD_0000 + 32'(i);
      end
      recv_len = len;
   endtask

   task automatic push_frame(input logic [31:0] base, input logic [LW-1:0] len);
      int l = eff_len(len);
      for (int i = 0; i < l; i++) begin
         sb.push_back({(i == l - 1), base + 32'(i)});
      end
   endtask

   // Caller sits just after a rising edge; returns just after the firing edge.
   task automatic send_frame(input logic [31:0] base, input logic [LW-1:0] len, output int waits);
      logic fired = 1'b0;
      waits = 0;
      load_frame(base, len);
      recv_val = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (recv_rdy) begin
            push_frame(base, len);
            fired = 1'b1;
            break;
         end
         waits++;
      end
      check("recv_fire", 64'(fired), 64'(1));
      @(posedge clk);
      #1;
      recv_val = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 300; t++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("drain", 64'(sb.size()), 64'(0));
      @(negedge clk);
      check("idle", 64'(send_val), 64'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      int fc0;
      logic found;
      for (int i = 0; i < NS; i++) recv_msg[i] = '0;

      #1 reset = 1'b1;
      #1;
      check("rst_recv_rdy", 64'(recv_rdy), 64'(1));
      check("rst_send_val", 64'(send_val), 64'(0));
      check("rst_send_last", 64'(send_last), 64'(0));
      check("rst_send_msg", 64'(send_msg), 64'(0));
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Single full frame.
      rdy_mode = 0;
      fc0 = fire_count;
      send_frame(32'h10, 4'd8, w);
      drain();
      check("f1_beats", 64'(fire_count - fc0), 64'(8));

      // Back-to-back frames with no bubble.
      fc0 = fire_count;
      send_frame(32'h40, 4'd8, w);
      send_frame(32'h80, 4'd3, w);
      check("b2b_rdy_wait", 64'(w), 64'(0));
      drain();
      check("b2b_beats", 64'(fire_count - fc0), 64'(11));
      check("b2b_run", 64'(run_len), 64'(11));

      // Backpressure.
      rdy_mode = 1;
      fc0 = fire_count;
      send_frame(32'hA0, 4'd5, w);
      drain();
      check("bp_beats", 64'(fire_count - fc0), 64'(5));
      rdy_mode = 0;
      @(posedge clk); #1;

      // Both banks full, third frame pending.
      rdy_mode = 2;
      @(posedge clk); #1;
      send_frame(32'h100, 4'd3, w);
      send_frame(32'h200, 4'd2, w);
      load_frame(32'h300, 4'd4);
      recv_val = 1'b1;
      @(negedge clk);
      check("full_rdy", 64'(recv_rdy), 64'(0));
      rdy_mode = 0;
      found = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (send_val && send_rdy && send_last && (send_msg == 32'h102)) begin
            check("full_rdy_at_last", 64'(recv_rdy), 64'(0));
            @(negedge clk);
            check("full_rdy_after", 64'(recv_rdy), 64'(1));
            push_frame(32'h300, 4'd4);
            found = 1'b1;
            break;
         end
      end
      check("full_last_seen", 64'(found), 64'(1));
      @(posedge clk); #1;
      recv_val = 1'b0;
      drain();

      // Length edge cases.
      fc0 = fire_count;
      send_frame(32'h900, 4'd1, w);
      drain();
      check("len1_beats", 64'(fire_count - fc0), 64'(1));
      fc0 = fire_count;
      send_frame(32'hA00, 4'd0, w);
      drain();
      check("len0_beats", 64'(fire_count - fc0), 64'(8));
      fc0 = fire_count;
      send_frame(32'hB00, 4'd12, w);
      drain();
      check("len12_beats", 64'(fire_count - fc0), 64'(8));

      // Reset mid-frame.
      fc0 = fire_count;
      send_frame(32'h500, 4'd8, w);
      for (int t = 0; t < 50; t++) begin
         if (fire_count - fc0 >= 3) break;
         @(negedge clk);
      end
      check("mid_beats", 64'(fire_count - fc0), 64'(3));
      #2 reset = 1'b1;
      #1;
      check("mid_rst_val", 64'(send_val), 64'(0));
      check("mid_rst_rdy", 64'(recv_rdy), 64'(1));
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_rdy", 64'(recv_rdy), 64'(1));
      check("post_rst_val", 64'(send_val), 64'(0));
      @(posedge clk); #1;
      fc0 = fire_count;
      send_frame(32'h600, 4'd5, w);
      drain();
      check("post_rst_beats", 64'(fire_count - fc0), 64'(5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Double-buffered, variable-length parallel-to-serial converter: accepts a frame of up to N_SAMPLES words in one val/rdy transfer and emits them one word per accepted output beat, lowest index first, with a last-word marker. The next generation of the sample serializer in the FFT/filter output path. Frame length is a run-time input. A second frame buffer lets the next frame be accepted while the current one streams, so back-to-back frames leave no bubble.

## Interface
- BIT_WIDTH, 32, width of one sample
- N_SAMPLES, 8, maximum samples per frame (≥2)
- LEN_W, $clog2(N_SAMPLES)+1, width of recv_len (derived; not overridden)

- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- recv_msg  input  BIT_WIDTH×N_SAMPLES (unpacked array)  frame samples; index 0 is sent first
- recv_len  input  LEN_W  number of valid samples in recv_msg
- recv_val  input  1  frame valid
- recv_rdy  output  1  frame buffer free
- send_msg  output  BIT_WIDTH  current sample
- send_last  output  1  send_msg is the final sample of its frame
- send_val  output  1  send_msg valid
- send_rdy  input  1  downstream accepts

## Operation
- Two banks, 0 and 1. Each bank holds:
  - N_SAMPLES data registers
  - a length register (LEN_W)
  - a state: EMPTY or FULL
- Pointers:
  - wr_bank: next bank to fill
  - rd_bank: bank being streamed
  - idx ($clog2(N_SAMPLES) bits): read index
- Length rule: effective length L = N_SAMPLES when recv_len == 0 or recv_len > N_SAMPLES; otherwise L = recv_len.
- Receive fire (recv_val && recv_rdy):
  - capture all of recv_msg and L into bank wr_bank
  - that bank becomes FULL
  - wr_bank toggles
- Output:
  - send_val = (bank rd_bank is FULL)
  - send_msg = data[rd_bank][idx]
  - send_last = send_val && (idx == L[rd_bank]−1)
- Send fire (send_val && send_rdy):
  - not last: idx increments
  - last: idx ← 0, bank rd_bank becomes EMPTY, rd_bank toggles
- recv_rdy = (bank wr_bank is EMPTY). It is a function of registered state only; there is no combinational path from send_rdy or recv_val.
- Data, length and pointers are frozen while send_val && !send_rdy. send_msg and send_last stay stable until accepted.

## Timing
- Reset values (asynchronous, take effect immediately):
  - both banks EMPTY; data and length registers 0
  - wr_bank = rd_bank = 0, idx = 0
  - recv_rdy = 1, send_val = 0, send_last = 0, send_msg = 0
- Latency: receive fire at edge t gives send_val = 1 in the cycle after t. The first sample is visible then.
- Throughput:
  - one sample per cycle while send_rdy = 1
  - a frame of L samples occupies L output cycles
  - if the other bank is FULL when the last sample fires, its sample 0 is presented in the next cycle (zero bubble)
- Both banks FULL: recv_rdy = 0. In the cycle the last sample of rd_bank fires, recv_rdy is still 0 and rises the following cycle.
- Simultaneous receive fire and last-sample fire on different banks are both honoured in the same edge.
- L = 1: send_last is asserted on sample 0 and the frame frees in one output beat.
- Reset asserted mid-frame: all buffered frames are discarded and send_val drops asynchronously. After deassertion the block is idle with recv_rdy = 1.
- recv_msg and recv_len are sampled only on a receive fire; values at other times are don't-care.

## Structure
- Package serializer_pkg holds:
  - bank_state_t enum {EMPTY, FULL}
  - the length-clamp function (recv_len → L)
- Sub-module frame_serializer_bank, instantiated twice. Each instance contains:
  - data array, length register and state, with load and free strobes
  - a read port indexed by idx
- Top level owns wr_bank, rd_bank, idx, the output mux and the handshake logic.

## Test plan
- Reset, then one frame: recv_msg = {0..7}+0x10, recv_len = 8, send_rdy = 1 → send_msg 0x10..0x17 on 8 consecutive cycles, send_last only on 0x17, then send_val = 0.
- Two back-to-back frames (lengths 8 and 3), send_rdy = 1 → 11 contiguous beats with no gap. send_last on beat 8 and beat 11. recv_rdy is held high while the second frame is accepted during streaming of the first.
- Backpressure: toggle send_rdy 1,0,0,1,… on a length-5 frame → each sample held stable while stalled, 5 accepted beats total, order preserved.
- Both banks full: third recv_val stays pending with recv_rdy = 0. recv_rdy rises exactly one cycle after the first frame's last beat fires, then the third frame streams after the second.
- Length edge cases: recv_len = 1 gives a single beat with send_last = 1. recv_len = 0 and recv_len = 12 with N_SAMPLES = 8 each give 8 beats.
- Reset asserted mid-frame after 3 beats → send_val = 0 immediately. After release recv_rdy = 1, and a new frame streams from its sample 0 with no residue from the old frame.
